// File: rtl/gpgpu_conf_regs_pkg.sv
// Register offsets, CTRL/STATUS bit positions and launch FSM state type
// shared by the GPGPU configuration register block.
package gpgpu_conf_regs_pkg;

  localparam logic [7:0] CTRL_OFFS      = 8'h00;
  localparam logic [7:0] START_OFFS     = 8'h04;
  localparam logic [7:0] STATUS_OFFS    = 8'h08;
  localparam logic [7:0] KERNEL_PC_OFFS = 8'h0C;
  localparam logic [7:0] NUM_WARPS_OFFS = 8'h10;
  localparam logic [7:0] CYCLES_OFFS    = 8'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_SRST   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} launch_state_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpgpu_conf_regs_if.sv
// OBI request and response interfaces between the host port and the
// configuration register block.
interface obi_req_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [3:0]              be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;

  modport master (output req, we, be, addr, wdata, input gnt);
  modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (input rvalid, rdata, err);
  modport slave  (output rvalid, rdata, err);
endinterface

// File: rtl/gpgpu_conf_regs_launch_fsm.sv
// Kernel launch sequencer plus optional RUN cycle counter
// (built only when GPGPU_CONF_PERF_CNT_EN is defined).
//
// state  | meaning
// IDLE   | no kernel in flight, launch requests may be accepted
// LAUNCH | parameters snapshotted, start pulse issued on exit
// RUN    | kernel executing, waiting for core_done
module gpgpu_launch_fsm
  import gpgpu_conf_regs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_req,
  input  logic        en,
  input  logic        srst,
  input  logic        num_warps_nz,
  input  logic        core_done,
  output logic        start_o,
  output logic        busy,
  output logic        launch,
  output logic        done_set,
  output logic        err_set,
  output logic [31:0] cycles
);

  launch_state_t state;

  assign launch   = start_req && (state == IDLE) && en && !srst && num_warps_nz;
  assign err_set  = start_req && !launch;
  assign done_set = core_done && (state == RUN) && !srst;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      start_o <= 1'b0;
      busy    <= 1'b0;
    end else if (srst) begin
      state   <= IDLE;
      start_o <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          start_o <= 1'b0;
          busy    <= 1'b0;
          if (launch) state <= LAUNCH;
        end
        LAUNCH: begin
          state   <= RUN;
          start_o <= 1'b1;
          busy    <= 1'b1;
        end
        RUN: begin
          start_o <= 1'b0;
          if (core_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          start_o <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPGPU_CONF_PERF_CNT_EN
  logic [31:0] cycles_q;

  // Counts every cycle spent in RUN, saturating rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (launch) begin
      cycles_q <= '0;
    end else if (state == RUN && cycles_q != 32'hFFFF_FFFF) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: rtl/gpgpu_conf_regs.sv
// OBI-slave configuration registers and kernel launch control for the GPGPU core.
// Optional RUN cycle counter enabled by defining GPGPU_CONF_PERF_CNT_EN.
module gpgpu_conf_regs
  import gpgpu_conf_regs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned NUM_WARPS_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  obi_req_if.slave               conf_regs_req,
  obi_rsp_if.slave               conf_regs_rsp,
  output logic                   core_en_o,
  output logic                   core_srst_o,
  output logic                   start_o,
  output logic [31:0]            kernel_pc_o,
  output logic [NUM_WARPS_W-1:0] num_warps_o,
  input  logic                   core_done_i,
  output logic                   irq_o
);

  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [31:0]            wmask;
  logic [7:0]             reg_offs;
  logic                   unused_addr;
  logic                   req, wr;

  logic [2:0]             ctrl_q;
  logic [31:0]            kernel_pc_q;
  logic [NUM_WARPS_W-1:0] num_warps_q;
  logic                   done_q, err_q;

  logic                   rvalid_q, rsp_err_q;
  logic [31:0]            rdata_q, rdata_d;
  logic                   addr_ok;

  logic                   start_req, busy, launch, done_set, err_set;
  logic                   clr_done, clr_err;
  logic [31:0]            cycles;

  assign addr        = conf_regs_req.addr;
  assign wdata       = conf_regs_req.wdata;
  assign wmask       = be_to_mask(conf_regs_req.be);
  assign reg_offs    = {addr[7:2], 2'b00};
  assign unused_addr = ^{addr[ADDR_WIDTH-1:8], addr[1:0]};

  // Grant is purely combinational; held low while in reset.
  assign req               = conf_regs_req.req && rst_ni;
  assign conf_regs_req.gnt = req;
  assign wr                = req && conf_regs_req.we;

  assign start_req = wr && (reg_offs == START_OFFS) && wdata[0] && wmask[0];
  assign clr_done  = wr && (reg_offs == STATUS_OFFS) && wdata[STATUS_DONE] && wmask[STATUS_DONE];
  assign clr_err   = wr && (reg_offs == STATUS_OFFS) && wdata[STATUS_ERR] && wmask[STATUS_ERR];

  gpgpu_launch_fsm u_launch_fsm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_req    (start_req),
    .en           (ctrl_q[CTRL_EN]),
    .srst         (ctrl_q[CTRL_SRST]),
    .num_warps_nz (|num_warps_q),
    .core_done    (core_done_i),
    .start_o      (start_o),
    .busy         (busy),
    .launch       (launch),
    .done_set     (done_set),
    .err_set      (err_set),
    .cycles       (cycles)
  );

  always_comb begin
    rdata_d = '0;
    addr_ok = 1'b1;
    case (reg_offs)
      CTRL_OFFS:      rdata_d[2:0] = ctrl_q;
      START_OFFS:     rdata_d = '0;
      STATUS_OFFS:    rdata_d[2:0] = {err_q, done_q, busy};
      KERNEL_PC_OFFS: rdata_d = kernel_pc_q;
      NUM_WARPS_OFFS: rdata_d[NUM_WARPS_W-1:0] = num_warps_q;
      CYCLES_OFFS:    rdata_d = cycles;
      default:        addr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q      <= '0;
      kernel_pc_q <= RESET_PC;
      num_warps_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      kernel_pc_o <= '0;
      num_warps_o <= '0;
      rvalid_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (wr && reg_offs == CTRL_OFFS)
        ctrl_q <= (ctrl_q & ~wmask[2:0]) | (wdata[2:0] & wmask[2:0]);
      if (wr && reg_offs == KERNEL_PC_OFFS)
        kernel_pc_q <= ((kernel_pc_q & ~wmask) | (wdata & wmask)) & 32'hFFFF_FFFC;
      if (wr && reg_offs == NUM_WARPS_OFFS)
        num_warps_q <= (num_warps_q & ~wmask[NUM_WARPS_W-1:0])
                     | (wdata[NUM_WARPS_W-1:0] & wmask[NUM_WARPS_W-1:0]);

      // Hardware set beats a same-cycle software clear.
      if (done_set)                done_q <= 1'b1;
      else if (launch || clr_done) done_q <= 1'b0;
      if (err_set)                 err_q  <= 1'b1;
      else if (clr_err)            err_q  <= 1'b0;

      if (launch) begin
        kernel_pc_o <= kernel_pc_q;
        num_warps_o <= num_warps_q;
      end

      rvalid_q  <= req;
      rsp_err_q <= req && !addr_ok;
      rdata_q   <= (req && !conf_regs_req.we && addr_ok) ? rdata_d : '0;
    end
  end

  assign conf_regs_rsp.rvalid = rvalid_q;
  assign conf_regs_rsp.rdata  = rdata_q;
  assign conf_regs_rsp.err    = rsp_err_q;

  assign core_en_o   = ctrl_q[CTRL_EN];
  assign core_srst_o = ctrl_q[CTRL_SRST];
  assign irq_o       = done_q && ctrl_q[CTRL_IRQ_EN];

endmodule
